scoreboard: RTL and testbench

SCOREBOARD -- requirements
Module: scoreboard

---
 rtl/scoreboard_pkg.sv | 22 ++
 rtl/scoreboard_if.sv | 46 ++++
 rtl/scoreboard_entry.sv | 51 +++++
 rtl/scoreboard.sv | 65 ++++++
 tb/tb_scoreboard.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scoreboard_pkg.sv
// Shared pipeline constants for the register scoreboard.
//   SB_NUM_REGS  number of architectural registers tracked
//   SB_ROW_W     width of each writeback timing row (bit k = writeback in k cycles)
//   SB_ADDR_W    register address width
//   SB_LAT_W     width of the issue latency field
//   SB_LAT_MIN / SB_LAT_MAX  legal issue latency bounds
//   lat_legal()  true when a latency value lies within the legal bounds
package scoreboard_pkg;

  localparam int SB_NUM_REGS = 32;
  localparam int SB_ROW_W    = 5;
  localparam int SB_ADDR_W   = 5;
  localparam int SB_LAT_W    = 3;

  localparam logic [SB_LAT_W-1:0] SB_LAT_MIN = 3'd1;
  localparam logic [SB_LAT_W-1:0] SB_LAT_MAX = 3'd4;

  function automatic logic lat_legal(input logic [SB_LAT_W-1:0] lat);
    return (lat >= SB_LAT_MIN) && (lat <= SB_LAT_MAX);
  endfunction

endpackage

// File: rtl/scoreboard_if.sv
// Scoreboard bus: issue-stage and decode-stage lookups, issue allocation,
// writeback completion and the writeback collision column.
//   slave  - the scoreboard (takes addresses/requests, returns lookups)
//   master - the pipeline driving it
interface scoreboard_if;
  import scoreboard_pkg::*;

  // issue-stage source lookups
  logic [SB_ADDR_W-1:0]   iss_addr_a, iss_addr_b;
  logic                   iss_ass_pending_a, iss_ass_pending_b;
  logic [SB_ROW_W-1:0]    iss_ass_row_a, iss_ass_row_b;
  // decode-stage source and destination lookups
  logic [SB_ADDR_W-1:0]   id_ass_addr_a, id_ass_addr_b, id_waw_addr;
  logic                   id_ass_pending_a, id_ass_pending_b;
  logic [SB_ROW_W-1:0]    id_ass_row_a, id_ass_row_b;
  logic                   id_ass_waw_write_pending;
  logic [SB_ROW_W-1:0]    id_ass_waw_write_row;
  // issue allocation
  logic                   iss_ass_writereg;
  logic [SB_ADDR_W-1:0]   iss_ass_writeaddr;
  logic [SB_LAT_W-1:0]    iss_latency;
  logic                   iss_stalled;
  logic [SB_NUM_REGS-1:0] sb_haz_column;
  // writeback completion
  logic                   wb_writereg;
  logic [SB_ADDR_W-1:0]   wb_writeaddr;

  modport slave (
    input  iss_addr_a, iss_addr_b, id_ass_addr_a, id_ass_addr_b, id_waw_addr,
           iss_ass_writereg, iss_ass_writeaddr, iss_latency, iss_stalled,
           wb_writereg, wb_writeaddr,
    output iss_ass_pending_a, iss_ass_pending_b, iss_ass_row_a, iss_ass_row_b,
           id_ass_pending_a, id_ass_pending_b, id_ass_row_a, id_ass_row_b,
           id_ass_waw_write_pending, id_ass_waw_write_row, sb_haz_column
  );

  modport master (
    output iss_addr_a, iss_addr_b, id_ass_addr_a, id_ass_addr_b, id_waw_addr,
           iss_ass_writereg, iss_ass_writeaddr, iss_latency, iss_stalled,
           wb_writereg, wb_writeaddr,
    input  iss_ass_pending_a, iss_ass_pending_b, iss_ass_row_a, iss_ass_row_b,
           id_ass_pending_a, id_ass_pending_b, id_ass_row_a, id_ass_row_b,
           id_ass_waw_write_pending, id_ass_waw_write_row, sb_haz_column
  );

endinterface

// File: rtl/scoreboard_entry.sv
// One scoreboard entry: pending flag plus writeback timing row.
//   clock, reset  rising-edge clock, synchronous active-high reset
//   alloc         load pending=1, row=1<<latency (wins over wb_clr)
//   wb_clr        clear pending; row keeps shifting
//   latency       issue latency used on allocation
//   pending, row  current entry state
module scoreboard_entry
  import scoreboard_pkg::*;
#(
  parameter int ROW_W = SB_ROW_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                alloc,
  input  logic                wb_clr,
  input  logic [SB_LAT_W-1:0] latency,
  output logic                pending,
  output logic [ROW_W-1:0]    row
);

  logic             pending_q, pending_d;
  logic [ROW_W-1:0] row_q, row_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    pending_d = pending_q;
    row_d     = row_q >> 1;
    if (wb_clr) pending_d = 1'b0;
    // Allocation is applied last so it overrides a same-cycle writeback.
    if (alloc) begin
      pending_d = 1'b1;
      row_d     = ROW_W'(1) << latency;
    end
  end

  // NOTE: state is updated with non-blocking assignments only; all entries are
  // reset because pending and row are architecturally visible, not scratch storage.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q <= 1'b0;
      row_q     <= '0;
    end else begin
      pending_q <= pending_d;
      row_q     <= row_d;
    end
  end

  assign pending = pending_q;
  assign row     = row_q;

endmodule

// File: rtl/scoreboard.sv
// Register scoreboard: tracks in-flight register writes and when each result
// reaches writeback. Five independent combinational read ports, one issue
// allocation port, one writeback clear port and a collision column that flags
// every register whose result lands in writeback after iss_latency cycles.
//   clock, reset  rising-edge clock, synchronous active-high reset
//   sb            scoreboard_if.slave bus (lookups, allocation, writeback)
// NUM_REGS and ROW_W must match the widths the interface takes from the package.
module scoreboard
  import scoreboard_pkg::*;
#(
  parameter int NUM_REGS = SB_NUM_REGS,
  parameter int ROW_W    = SB_ROW_W
) (
  input  logic               clock,
  input  logic               reset,
  scoreboard_if.slave        sb
);

  logic [NUM_REGS-1:0]            pend;
  logic [NUM_REGS-1:0][ROW_W-1:0] rows;
  logic                           alloc_ok;

  // Illegal latencies (0, 5..7) and register 0 never allocate.
  assign alloc_ok = sb.iss_ass_writereg && !sb.iss_stalled &&
                    (sb.iss_ass_writeaddr != '0) && lat_legal(sb.iss_latency);

  // Register 0 is hard-wired empty.
  assign pend[0] = 1'b0;
  assign rows[0] = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    scoreboard_entry #(.ROW_W(ROW_W)) u_entry (
      .clock   (clock),
      .reset   (reset),
      .alloc   (alloc_ok && (sb.iss_ass_writeaddr == SB_ADDR_W'(r))),
      .wb_clr  (sb.wb_writereg && (sb.wb_writeaddr == SB_ADDR_W'(r))),
      .latency (sb.iss_latency),
      .pending (pend[r]),
      .row     (rows[r])
    );
  end

  // Read ports: plain muxes over current state.
  assign sb.iss_ass_pending_a        = pend[sb.iss_addr_a];
  assign sb.iss_ass_row_a            = rows[sb.iss_addr_a];
  assign sb.iss_ass_pending_b        = pend[sb.iss_addr_b];
  assign sb.iss_ass_row_b            = rows[sb.iss_addr_b];
  assign sb.id_ass_pending_a         = pend[sb.id_ass_addr_a];
  assign sb.id_ass_row_a             = rows[sb.id_ass_addr_a];
  assign sb.id_ass_pending_b         = pend[sb.id_ass_addr_b];
  assign sb.id_ass_row_b             = rows[sb.id_ass_addr_b];
  assign sb.id_ass_waw_write_pending = pend[sb.id_waw_addr];
  assign sb.id_ass_waw_write_row     = rows[sb.id_waw_addr];

  // Column slice of the timing rows at the issuing instruction's latency.
  always_comb begin
    sb.sb_haz_column = '0;
    if (lat_legal(sb.iss_latency)) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        sb.sb_haz_column[r] = rows[r][sb.iss_latency];
      end
    end
  end

endmodule

// File: tb/tb_scoreboard.sv
// Directed bench for the scoreboard: reset, allocation and row shifting,
// stalled issue, writeback clear, allocate/writeback collision, collision
// column, register 0, independent read ports and reset of live entries.
module tb_scoreboard;

  logic clock = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  scoreboard_if sb ();

  scoreboard u_dut (
    .clock (clock),
    .reset (reset),
    .sb    (sb)
  );

  always #5 clock = ~clock;

  // Advance one rising edge and settle past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    sb.iss_ass_writereg  = 1'b0;
    sb.iss_ass_writeaddr = '0;
    sb.iss_latency       = 3'd1;
    sb.iss_stalled       = 1'b0;
    sb.wb_writereg       = 1'b0;
    sb.wb_writeaddr      = '0;
  endtask

  task automatic set_reads(input logic [4:0] ia, ib, da, db, dw);
    sb.iss_addr_a    = ia;
    sb.iss_addr_b    = ib;
    sb.id_ass_addr_a = da;
    sb.id_ass_addr_b = db;
    sb.id_waw_addr   = dw;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    set_reads(5'd1, 5'd5, 5'd9, 5'd17, 5'd31);
    step();
    step();
    reset = 1'b0;
    if ({sb.iss_ass_pending_a, sb.iss_ass_pending_b, sb.id_ass_pending_a,
         sb.id_ass_pending_b, sb.id_ass_waw_write_pending} !== 5'b0) begin
      $display("FAIL reset_pending got %b exp 00000", {sb.iss_ass_pending_a, sb.iss_ass_pending_b,
               sb.id_ass_pending_a, sb.id_ass_pending_b, sb.id_ass_waw_write_pending});
      miscompares++;
    end
    vectors++;
    if ({sb.iss_ass_row_a, sb.iss_ass_row_b, sb.id_ass_row_a, sb.id_ass_row_b,
         sb.id_ass_waw_write_row} !== 25'b0) begin
      $display("FAIL reset_rows got %h exp 0", {sb.iss_ass_row_a, sb.iss_ass_row_b,
               sb.id_ass_row_a, sb.id_ass_row_b, sb.id_ass_waw_write_row});
      miscompares++;
    end
    vectors++;
    sb.iss_latency = 3'd4;
    #1;
    if (sb.sb_haz_column !== 32'h0) begin
      $display("FAIL reset_column got %h exp 00000000", sb.sb_haz_column);
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_alloc_shift();
    logic [4:0] exp_rows [5];
    exp_rows[0] = 5'b01000; exp_rows[1] = 5'b00100; exp_rows[2] = 5'b00010;
    exp_rows[3] = 5'b00001; exp_rows[4] = 5'b00000;
    idle_inputs();
    sb.iss_ass_writereg  = 1'b1;
    sb.iss_ass_writeaddr = 5'd5;
    sb.iss_latency       = 3'd3;
    set_reads(5'd5, 5'd0, 5'd5, 5'd0, 5'd5);
    // The allocation must not be visible before the edge.
    if (sb.iss_ass_pending_a !== 1'b0) begin
      $display("FAIL alloc_same_cycle got %b exp 0", sb.iss_ass_pending_a);
      miscompares++;
    end
    vectors++;
    step();
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      #1;
      if (sb.iss_ass_pending_a !== 1'b1 || sb.iss_ass_row_a !== exp_rows[i]) begin
        $display("FAIL alloc_shift_%0d got pend=%b row=%b exp pend=1 row=%b",
                 i, sb.iss_ass_pending_a, sb.iss_ass_row_a, exp_rows[i]);
        miscompares++;
      end
      vectors++;
      if (sb.id_ass_row_a !== exp_rows[i] || sb.id_ass_waw_write_row !== exp_rows[i]) begin
        $display("FAIL alloc_id_rows_%0d got %b/%b exp %b", i, sb.id_ass_row_a,
                 sb.id_ass_waw_write_row, exp_rows[i]);
        miscompares++;
      end
      vectors++;
      if (i < 4) step();
    end
  endtask

  task automatic test_stall();
    idle_inputs();
    sb.iss_ass_writereg  = 1'b1;
    sb.iss_ass_writeaddr = 5'd7;
    sb.iss_latency       = 3'd2;
    sb.iss_stalled       = 1'b1;
    set_reads(5'd7, 5'd7, 5'd7, 5'd7, 5'd7);
    step();
    idle_inputs();
    #1;
    if (sb.iss_ass_pending_b !== 1'b0 || sb.iss_ass_row_b !== 5'b0) begin
      $display("FAIL stall_r7 got pend=%b row=%b exp pend=0 row=00000",
               sb.iss_ass_pending_b, sb.iss_ass_row_b);
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_writeback();
    // r5 is still pending from the allocation test.
    idle_inputs();
    sb.wb_writereg  = 1'b1;
    sb.wb_writeaddr = 5'd5;
    set_reads(5'd5, 5'd0, 5'd0, 5'd0, 5'd0);
    step();
    idle_inputs();
    #1;
    if (sb.iss_ass_pending_a !== 1'b0) begin
      $display("FAIL wb_clear_r5 got %b exp 0", sb.iss_ass_pending_a);
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_alloc_wb_same();
    idle_inputs();
    sb.iss_ass_writereg  = 1'b1;
    sb.iss_ass_writeaddr = 5'd9;
    sb.iss_latency       = 3'd4;
    set_reads(5'd9, 5'd9, 5'd9, 5'd9, 5'd9);
    step();
    // r9 now pending with row 10000; overwrite with latency 2 while writing back.
    sb.iss_latency  = 3'd2;
    sb.wb_writereg  = 1'b1;
    sb.wb_writeaddr = 5'd9;
    step();
    idle_inputs();
    #1;
    if (sb.id_ass_pending_b !== 1'b1 || sb.id_ass_row_b !== 5'b00100) begin
      $display("FAIL alloc_wb_r9 got pend=%b row=%b exp pend=1 row=00100",
               sb.id_ass_pending_b, sb.id_ass_row_b);
      miscompares++;
    end
    vectors++;
    repeat (4) step();
    if (sb.id_ass_row_b !== 5'b0 || sb.id_ass_pending_b !== 1'b1) begin
      $display("FAIL drain_r9 got pend=%b row=%b exp pend=1 row=00000",
               sb.id_ass_pending_b, sb.id_ass_row_b);
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_haz_column();
    logic [2:0]  lats [4];
    logic [31:0] exps [4];
    lats[0] = 3'd2; exps[0] = 32'h0000_0008;
    lats[1] = 3'd1; exps[1] = 32'h0000_0000;
    lats[2] = 3'd0; exps[2] = 32'h0000_0000;
    lats[3] = 3'd5; exps[3] = 32'h0000_0000;
    idle_inputs();
    sb.iss_ass_writereg  = 1'b1;
    sb.iss_ass_writeaddr = 5'd3;
    sb.iss_latency       = 3'd2;
    step();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      sb.iss_latency = lats[i];
      #1;
      if (sb.sb_haz_column !== exps[i]) begin
        $display("FAIL haz_column_lat%0d got %h exp %h", lats[i], sb.sb_haz_column, exps[i]);
        miscompares++;
      end
      vectors++;
    end
    // Latency 0 must not allocate.
    sb.iss_ass_writereg  = 1'b1;
    sb.iss_ass_writeaddr = 5'd12;
    sb.iss_latency       = 3'd0;
    set_reads(5'd12, 5'd0, 5'd0, 5'd0, 5'd0);
    step();
    idle_inputs();
    #1;
    if (sb.iss_ass_pending_a !== 1'b0 || sb.iss_ass_row_a !== 5'b0) begin
      $display("FAIL lat0_no_alloc got pend=%b row=%b exp pend=0 row=00000",
               sb.iss_ass_pending_a, sb.iss_ass_row_a);
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_r0();
    idle_inputs();
    sb.iss_ass_writereg  = 1'b1;
    sb.iss_ass_writeaddr = 5'd0;
    sb.iss_latency       = 3'd4;
    set_reads(5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    step();
    sb.iss_ass_writereg = 1'b0;
    #1;
    if ({sb.iss_ass_pending_a, sb.iss_ass_pending_b, sb.id_ass_pending_a,
         sb.id_ass_pending_b, sb.id_ass_waw_write_pending} !== 5'b0 ||
        {sb.iss_ass_row_a, sb.iss_ass_row_b, sb.id_ass_row_a, sb.id_ass_row_b,
         sb.id_ass_waw_write_row} !== 25'b0) begin
      $display("FAIL r0_reads got pend=%b rows=%h exp all 0", {sb.iss_ass_pending_a,
               sb.iss_ass_pending_b, sb.id_ass_pending_a, sb.id_ass_pending_b,
               sb.id_ass_waw_write_pending}, {sb.iss_ass_row_a, sb.iss_ass_row_b,
               sb.id_ass_row_a, sb.id_ass_row_b, sb.id_ass_waw_write_row});
      miscompares++;
    end
    vectors++;
    if (sb.sb_haz_column[0] !== 1'b0) begin
      $display("FAIL r0_column got %b exp 0", sb.sb_haz_column[0]);
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_ports_and_reset();
    idle_inputs();
    sb.iss_ass_writereg  = 1'b1;
    sb.iss_ass_writeaddr = 5'd4;
    sb.iss_latency       = 3'd4;
    step();
    sb.iss_ass_writeaddr = 5'd10;
    sb.iss_latency       = 3'd1;
    step();
    idle_inputs();
    // r4 row 01000, r10 row 00010, both pending.
    set_reads(5'd4, 5'd10, 5'd10, 5'd4, 5'd4);
    if ({sb.iss_ass_pending_a, sb.iss_ass_pending_b, sb.id_ass_pending_a,
         sb.id_ass_pending_b, sb.id_ass_waw_write_pending} !== 5'b11111) begin
      $display("FAIL ports_pending got %b exp 11111", {sb.iss_ass_pending_a,
               sb.iss_ass_pending_b, sb.id_ass_pending_a, sb.id_ass_pending_b,
               sb.id_ass_waw_write_pending});
      miscompares++;
    end
    vectors++;
    if ({sb.iss_ass_row_a, sb.iss_ass_row_b, sb.id_ass_row_a, sb.id_ass_row_b,
         sb.id_ass_waw_write_row} !== {5'b01000, 5'b00010, 5'b00010, 5'b01000, 5'b01000}) begin
      $display("FAIL ports_rows got %b exp 01000_00010_00010_01000_01000", {sb.iss_ass_row_a,
               sb.iss_ass_row_b, sb.id_ass_row_a, sb.id_ass_row_b, sb.id_ass_waw_write_row});
      miscompares++;
    end
    vectors++;
    sb.iss_latency = 3'd3;
    #1;
    if (sb.sb_haz_column !== 32'h0000_0010) begin
      $display("FAIL ports_column_lat3 got %h exp 00000010", sb.sb_haz_column);
      miscompares++;
    end
    vectors++;
    sb.iss_latency = 3'd1;
    #1;
    if (sb.sb_haz_column !== 32'h0000_0400) begin
      $display("FAIL ports_column_lat1 got %h exp 00000400", sb.sb_haz_column);
      miscompares++;
    end
    vectors++;
    // One-cycle reset also overrides a simultaneous allocation to r4.
    reset                = 1'b1;
    sb.iss_ass_writereg  = 1'b1;
    sb.iss_ass_writeaddr = 5'd4;
    sb.iss_latency       = 3'd4;
    step();
    reset = 1'b0;
    idle_inputs();
    #1;
    if ({sb.iss_ass_pending_a, sb.iss_ass_pending_b, sb.id_ass_pending_a,
         sb.id_ass_pending_b, sb.id_ass_waw_write_pending} !== 5'b0 ||
        {sb.iss_ass_row_a, sb.iss_ass_row_b, sb.id_ass_row_a, sb.id_ass_row_b,
         sb.id_ass_waw_write_row} !== 25'b0) begin
      $display("FAIL live_reset got pend=%b rows=%h exp all 0", {sb.iss_ass_pending_a,
               sb.iss_ass_pending_b, sb.id_ass_pending_a, sb.id_ass_pending_b,
               sb.id_ass_waw_write_pending}, {sb.iss_ass_row_a, sb.iss_ass_row_b,
               sb.id_ass_row_a, sb.id_ass_row_b, sb.id_ass_waw_write_row});
      miscompares++;
    end
    vectors++;
  endtask

  initial begin
    test_reset();
    test_alloc_shift();
    test_stall();
    test_writeback();
    test_alloc_wb_same();
    test_haz_column();
    test_r0();
    test_ports_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
